// File: rtl/traffic_fsm.sv
// traffic_fsm -- main controller for a two-road intersection (main/side street)
// with a pedestrian walk phase.
//
// Phase sequence: main green -> main yellow -> [walk] -> side green
// [-> side green extension] -> side yellow -> main green. Every phase is timed
// in 1 Hz ticks; transitions happen only on tick cycles. Lamp outputs are
// registered and decoded from the state being entered, so they change on the
// same edge as the state.
//
// Optional feature macro: TLC_SIDE_EXT_EN
//   defined   : S_SG_EXT exists; side green is stretched by T_EXT ticks when
//               a side-street car is still present at base expiry.
//   undefined : S_SG always proceeds to S_SY; T_EXT is only range-checked.
//
// Parameters:
//   T_BASE  main-green minimum and base side-green duration (ticks)
//   T_EXT   side-green extension (ticks)
//   T_YEL   yellow duration (ticks)
//   T_WALK  walk-phase duration (ticks)
//   TW      timer width; every duration must be in 1..2^TW-1
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   tick        one-clk-wide 1 Hz enable
//   sensor      side-street car present (synchronous)
//   wr          latched walk request from the walk register
//   main_light  {R,Y,G} one-hot, main street
//   side_light  {R,Y,G} one-hot, side street
//   walk        pedestrian walk lamp
//   wr_reset    clear strobe to the walk register
module traffic_fsm #(
  parameter int unsigned T_BASE = 6,
  parameter int unsigned T_EXT  = 3,
  parameter int unsigned T_YEL  = 2,
  parameter int unsigned T_WALK = 3,
  parameter int unsigned TW     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sensor,
  input  logic       wr,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       wr_reset
);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int unsigned CNT_MAX = (1 << TW) - 1;

  localparam logic [TW-1:0] CNT_ONE  = TW'(1);
  localparam logic [TW-1:0] CNT_BASE = TW'(T_BASE);
  localparam logic [TW-1:0] CNT_YEL  = TW'(T_YEL);
  localparam logic [TW-1:0] CNT_WALK = TW'(T_WALK);
`ifdef TLC_SIDE_EXT_EN
  localparam logic [TW-1:0] CNT_EXT  = TW'(T_EXT);
`endif

  // Reject durations that would be truncated by the timer width or never expire.
  if (T_BASE < 1 || T_BASE > CNT_MAX ||
      T_EXT  < 1 || T_EXT  > CNT_MAX ||
      T_YEL  < 1 || T_YEL  > CNT_MAX ||
      T_WALK < 1 || T_WALK > CNT_MAX) begin : g_bad_duration
    $error("traffic_fsm: every duration must be in 1..2^TW-1");
  end

  typedef enum logic [2:0] {
    S_MG     = 3'd0,
    S_MY     = 3'd1,
    S_WALK   = 3'd2,
    S_SG     = 3'd3,
`ifdef TLC_SIDE_EXT_EN
    S_SG_EXT = 3'd4,
`endif
    S_SY     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    main_q, main_d;
  logic [2:0]    side_q, side_d;
  logic          walk_q, walk_d;
  logic          wr_reset_q, wr_reset_d;

  logic          wr_eff;
  logic          done;

  function automatic logic [TW-1:0] dur(input state_e s);
    logic [TW-1:0] d;
    case (s)
      S_MG, S_SG: d = CNT_BASE;
      S_MY, S_SY: d = CNT_YEL;
      S_WALK:     d = CNT_WALK;
`ifdef TLC_SIDE_EXT_EN
      S_SG_EXT:   d = CNT_EXT;
`endif
      default:    d = CNT_BASE;
    endcase
    return d;
  endfunction

  // Next state and timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // The walk register is being cleared while wr_reset is high; its output
    // is stale during that cycle.
    wr_eff  = wr & ~wr_reset_q;
    // cnt==0 only occurs in the main-green hold; treating it as expired lets
    // that hold take a request on any tick (and recovers a corrupted timer).
    done    = tick && (cnt_q <= CNT_ONE);

    if (tick && (cnt_q > CNT_ONE)) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    case (state_q)
      S_MG: begin
        if (done) begin
          if (sensor | wr_eff) state_d = S_MY;
          else                 cnt_d   = '0;
        end
      end
      S_MY: begin
        if (done) state_d = wr_eff ? S_WALK : S_SG;
      end
      S_WALK: begin
        if (done) state_d = sensor ? S_SG : S_MG;
      end
      S_SG: begin
`ifdef TLC_SIDE_EXT_EN
        if (done) state_d = sensor ? S_SG_EXT : S_SY;
`else
        if (done) state_d = S_SY;
`endif
      end
`ifdef TLC_SIDE_EXT_EN
      // Always leaves for yellow, so the extension is granted once per phase.
      S_SG_EXT: begin
        if (done) state_d = S_SY;
      end
`endif
      S_SY: begin
        if (done) state_d = S_MG;
      end
      default: state_d = S_MG;
    endcase

    // No state loops to itself, so a change of state is exactly an entry.
    if (state_d != state_q) begin
      cnt_d = dur(state_d);
    end
  end

  // Moore outputs decoded from the state being entered, then registered.
  always_comb begin
    main_d     = LAMP_R;
    side_d     = LAMP_R;
    walk_d     = 1'b0;
    wr_reset_d = (state_d == S_WALK) && (state_q != S_WALK);
    case (state_d)
      S_MG:     main_d = LAMP_G;
      S_MY:     main_d = LAMP_Y;
      S_WALK:   walk_d = 1'b1;
      S_SG:     side_d = LAMP_G;
`ifdef TLC_SIDE_EXT_EN
      S_SG_EXT: side_d = LAMP_G;
`endif
      S_SY:     side_d = LAMP_Y;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_MG;
      cnt_q      <= CNT_BASE;
      main_q     <= LAMP_G;
      side_q     <= LAMP_R;
      walk_q     <= 1'b0;
      wr_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      main_q     <= main_d;
      side_q     <= side_d;
      walk_q     <= walk_d;
      wr_reset_q <= wr_reset_d;
    end
  end

  assign main_light = main_q;
  assign side_light = side_q;
  assign walk       = walk_q;
  assign wr_reset   = wr_reset_q;

endmodule
